digit_serial_adder_ctrl: RTL and testbench
==========================================

# digit_serial_adder_ctrl

Multi-cycle controller that adds two wide unsigned operands one 3-bit digit per cycle by driving the team's combinational 3-bit adder stage (inputs `dina`/`dinb`/`cin`, outputs `sum`/`cout`) and collecting its results. It sits directly upstream of that adder, slicing and sequencing operands and chaining the carry. It also sits directly downstream of the adder, registering each digit sum into the assembled result. Operand intake and result delivery use valid/ready handshakes.

## Interface
- `DIGITS`, default 4: number of 3-bit digits per operand; operand/result width is `3*DIGITS`. Legal range 2..16.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; synchronous and active-high.
- `start_valid`  input  1  operands presented.
- `start_ready`  output  1  controller can accept operands.
- `a_in`  input  3*DIGITS  operand A, unsigned.
- `b_in`  input  3*DIGITS  operand B, unsigned.
- `cin_in`  input  1  initial carry-in.
- `dina`  output  3  digit of A to adder.
- `dinb`  output  3  digit of B to adder.
- `cin`  output  1  carry to adder.
- `sum`  input  3  adder digit sum; combinational, valid same cycle.
- `cout`  input  1  adder carry-out; combinational, valid same cycle.
- `res_valid`  output  1  result available.
- `res_ready`  input  1  consumer accepts result.
- `result`  output  3*DIGITS  assembled sum.
- `cout_out`  output  1  final carry-out.

## Operation
- States: IDLE, RUN, DONE. Digit index `idx` counts 0..DIGITS-1. Digit 0 is the least-significant 3 bits.
- IDLE:
  - `start_ready`=1.
  - On `start_valid`: capture `a_in`, `b_in` into internal registers, load carry register with `cin_in`, set `idx`=0, go to RUN.
- RUN:
  - `dina`=A digit `idx`, `dinb`=B digit `idx`, `cin`=carry register.
  - Each cycle: write `sum` into result digit `idx`, load carry register with `cout`, increment `idx`.
  - When `idx`=DIGITS-1, also load `cout_out` with `cout` and go to DONE.
- DONE:
  - `res_valid`=1.
  - On `res_ready`, go to IDLE.
- Adder drive: outside RUN, `dina`, `dinb`, and `cin` are driven to 0.
- Input changes: changes on `a_in`, `b_in`, and `cin_in` after capture are ignored.
- `result` and `cout_out`:
  - Result digits are written in place as RUN proceeds, so `result` is meaningful only while `res_valid`=1.
  - Both hold their values after leaving DONE until overwritten by the next operation.
- Arithmetic: `result` = (A + B + `cin_in`) mod 2^(3*DIGITS). `cout_out` = bit 3*DIGITS of that sum.
- No digit is ever skipped. The carry ripples strictly one digit per cycle.

## Timing
- Reset (`rst`=1 at a rising edge):
  - State goes to IDLE; `idx`=0; carry register=0.
  - `result`=0, `cout_out`=0, `res_valid`=0; `dina`/`dinb`/`cin`=0.
- `start_ready` is 0 whenever `rst`=1, otherwise 1 exactly in IDLE.
- Latency:
  - Operands are accepted at edge E0.
  - RUN occupies the DIGITS cycles following E0.
  - `res_valid` rises after edge E0+DIGITS.
  - Minimum issue interval is DIGITS+2 cycles.
- `start_valid` while not ready: ignored; no operands are captured.
- Backpressure: while `res_ready`=0 in DONE, `res_valid`, `result`, and `cout_out` hold stable indefinitely.
- Simultaneous events:
  - `res_ready` and `start_valid` both high in DONE: the result is consumed and the new operands are not accepted, since `start_ready`=0.
  - The new operands are accepted in the following IDLE cycle if `start_valid` is still high.
- Reset mid-operation: `rst` in RUN or DONE aborts the operation. Next cycle the block is in IDLE with reset values and no `res_valid` pulse.

## Test plan
- DIGITS=4, A=12'o0001, B=12'o0005, cin=0:
  - `result`=12'o0006, `cout_out`=0.
  - `res_valid` appears exactly 4 cycles after accept.
- A=12'o0002, B=12'o0007, cin=1:
  - Digit 0 produces `sum`=2 with carry 1 into digit 1.
  - `result`=12'o0012, `cout_out`=0.
- A=12'o7777, B=12'o0001, cin=0:
  - The carry ripples through all 4 digits; `cin` to the adder is 0,1,1,1.
  - `result`=0, `cout_out`=1.
- A=12'o1234, B=12'o4321, cin=0:
  - `dina` sequence is 4,3,2,1 and `dinb` sequence is 1,2,3,4 in consecutive RUN cycles.
  - `result`=12'o5555; `a_in` is changed during RUN with no effect.
- Backpressure: hold `res_ready`=0 for 5 cycles in DONE.
  - `res_valid`/`result` remain stable and `start_ready`=0.
  - Raising `res_ready` together with `start_valid` consumes the result; the new operands are accepted one cycle later.
- Assert `rst` when `idx`=2:
  - Next cycle: state IDLE, `result`=0, `res_valid`=0, `start_ready`=1, adder inputs 0.
  - A subsequent operation completes correctly.

Source files
------------

// File: rtl/digit_serial_adder_ctrl.sv
// Digit-serial adder sequencer: feeds one 3-bit digit pair per cycle to an external
// combinational 3-bit adder, chains its carry and assembles the wide sum.
module digit_serial_adder_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [3*DIGITS-1:0]   a_in,
   input  logic [3*DIGITS-1:0]   b_in,
   input  logic                  cin_in,
   output logic [2:0]            dina,
   output logic [2:0]            dinb,
   output logic                  cin,
   input  logic [2:0]            sum,
   input  logic                  cout,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [3*DIGITS-1:0]   result,
   output logic                  cout_out
);

   localparam int W    = 3 * DIGITS;
   localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic              carry_q, carry_d;
   logic [W-1:0]      result_q, result_d;
   logic              cout_out_q, cout_out_d;

   logic [31:0]       lsb_s;
   logic [2:0]        dina_s;
   logic [2:0]        dinb_s;
   logic              cin_s;
   logic              start_ready_s;
   logic              res_valid_s;

   // State register; synchronous reset returns every flop to its idle value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= {IDXW{1'b0}};
         a_q        <= {W{1'b0}};
         b_q        <= {W{1'b0}};
         carry_q    <= 1'b0;
         result_q   <= {W{1'b0}};
         cout_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         a_q        <= a_d;
         b_q        <= b_d;
         carry_q    <= carry_d;
         result_q   <= result_d;
         cout_out_q <= cout_out_d;
      end
   end

   // Next-state, digit sequencing and adder drive.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      a_d           = a_q;
      b_d           = b_q;
      carry_d       = carry_q;
      result_d      = result_q;
      cout_out_d    = cout_out_q;
      lsb_s         = 32'd3 * 32'(idx_q);
      dina_s        = 3'd0;
      dinb_s        = 3'd0;
      cin_s         = 1'b0;
      start_ready_s = 1'b0;
      res_valid_s   = 1'b0;
      case (state_q)
         IDLE: begin
            start_ready_s = ~rst;
            if (start_valid) begin
               a_d     = a_in;
               b_d     = b_in;
               carry_d = cin_in;
               idx_d   = {IDXW{1'b0}};
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            dina_s               = a_q[lsb_s +: 3];
            dinb_s               = b_q[lsb_s +: 3];
            cin_s                = carry_q;
            result_d[lsb_s +: 3] = sum;
            carry_d              = cout;
            // The last digit's carry-out is the overall carry of the wide sum.
            if (idx_q == LAST_IDX) begin
               cout_out_d = cout;
               idx_d      = {IDXW{1'b0}};
               state_d    = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = RUN;
            end
         end
         DONE: begin
            res_valid_s = 1'b1;
            if (res_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign start_ready = start_ready_s;
   assign res_valid   = res_valid_s;
   assign dina        = dina_s;
   assign dinb        = dinb_s;
   assign cin         = cin_s;
   assign result      = result_q;
   assign cout_out    = cout_out_q;

endmodule

// File: tb/tb_digit_serial_adder_ctrl.sv
// Directed bench for digit_serial_adder_ctrl (DIGITS=4) with a behavioural 3-bit adder
// closing the loop between the controller's adder drive and its sum/cout inputs.
module tb_digit_serial_adder_ctrl;

   logic        clk;
   logic        rst;
   logic        start_valid;
   logic        start_ready;
   logic [11:0] a_in;
   logic [11:0] b_in;
   logic        cin_in;
   logic [2:0]  dina;
   logic [2:0]  dinb;
   logic        cin;
   logic [2:0]  sum;
   logic        cout;
   logic        res_valid;
   logic        res_ready;
   logic [11:0] result;
   logic        cout_out;

   int checks;
   int errors;

   digit_serial_adder_ctrl #(.DIGITS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a_in        (a_in),
      .b_in        (b_in),
      .cin_in      (cin_in),
      .dina        (dina),
      .dinb        (dinb),
      .cin         (cin),
      .sum         (sum),
      .cout        (cout),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .result      (result),
      .cout_out    (cout_out)
   );

   assign {cout, sum} = {1'b0, dina} + {1'b0, dinb} + {3'd0, cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents operands for one accept edge, scrambles the inputs afterwards and records
   // the per-digit adder drive until res_valid rises (bounded by 20 cycles).
   task automatic issue(input logic [11:0] a, input logic [11:0] b, input logic c,
                        output int lat, output logic [11:0] da_tr,
                        output logic [11:0] db_tr, output logic [3:0] ci_tr);
      a_in = a; b_in = b; cin_in = c; start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      a_in = ~a; b_in = ~b; cin_in = ~c;
      lat = 0; da_tr = 12'd0; db_tr = 12'd0; ci_tr = 4'd0;
      while (!res_valid && lat < 20) begin
         if (lat < 4) begin
            da_tr[3*lat +: 3] = dina;
            db_tr[3*lat +: 3] = dinb;
            ci_tr[lat]        = cin;
         end
         step();
         lat++;
      end
   endtask

   task automatic consume();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
      a_in = 12'd0; b_in = 12'd0; cin_in = 1'b0;
      step(); step();
      checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL rst_start_ready got %b exp 0", start_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
      checks++; if (result !== 12'd0 || cout_out !== 1'b0) begin errors++; $display("FAIL rst_result got %o/%b exp 0/0", result, cout_out); end
      checks++; if ({dina, dinb, cin} !== 7'd0) begin errors++; $display("FAIL rst_adder_drive got %o %o %b exp 0", dina, dinb, cin); end
      rst = 1'b0;
      #1;
      checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL idle_start_ready got %b exp 1", start_ready); end
   endtask

   task automatic test_basic();
      int lat; logic [11:0] da, db; logic [3:0] ci;
      issue(12'o0001, 12'o0005, 1'b0, lat, da, db, ci);
      checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", lat); end
      checks++; if (result !== 12'o0006 || cout_out !== 1'b0) begin errors++; $display("FAIL basic_result got %o/%b exp 0006/0", result, cout_out); end
      checks++; if ({dina, dinb, cin} !== 7'd0) begin errors++; $display("FAIL done_adder_drive got %o %o %b exp 0", dina, dinb, cin); end
      consume();
      checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL basic_consume got valid %b ready %b exp 0 1", res_valid, start_ready); end
   endtask

   task automatic test_carry_in();
      int lat; logic [11:0] da, db; logic [3:0] ci;
      issue(12'o0002, 12'o0007, 1'b1, lat, da, db, ci);
      checks++; if (ci !== 4'b0011) begin errors++; $display("FAIL cin_carry_seq got %b exp 0011", ci); end
      checks++; if (result !== 12'o0012 || cout_out !== 1'b0) begin errors++; $display("FAIL cin_result got %o/%b exp 0012/0", result, cout_out); end
      consume();
   endtask

   task automatic test_ripple();
      int lat; logic [11:0] da, db; logic [3:0] ci;
      issue(12'o7777, 12'o0001, 1'b0, lat, da, db, ci);
      checks++; if (ci !== 4'b1110) begin errors++; $display("FAIL ripple_carry_seq got %b exp 1110", ci); end
      checks++; if (result !== 12'o0000 || cout_out !== 1'b1) begin errors++; $display("FAIL ripple_result got %o/%b exp 0000/1", result, cout_out); end
      consume();
   endtask

   task automatic test_digit_order();
      int lat; logic [11:0] da, db; logic [3:0] ci;
      issue(12'o1234, 12'o4321, 1'b0, lat, da, db, ci);
      checks++; if (da !== 12'o1234) begin errors++; $display("FAIL dina_seq got %o exp 1234", da); end
      checks++; if (db !== 12'o4321) begin errors++; $display("FAIL dinb_seq got %o exp 4321", db); end
      checks++; if (result !== 12'o5555 || cout_out !== 1'b0) begin errors++; $display("FAIL order_result got %o/%b exp 5555/0", result, cout_out); end
      consume();
   endtask

   task automatic test_back_to_back();
      int lat; logic [11:0] da, db; logic [3:0] ci;
      issue(12'o0100, 12'o0200, 1'b0, lat, da, db, ci);
      a_in = 12'o0011; b_in = 12'o0022; cin_in = 1'b0; start_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (res_valid !== 1'b1 || result !== 12'o0300 || start_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold cyc %0d got valid %b result %o ready %b exp 1 0300 0", k, res_valid, result, start_ready);
         end
         step();
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL b2b_not_accepted got valid %b ready %b exp 0 1", res_valid, start_ready); end
      step();
      start_valid = 1'b0;
      checks++; if (start_ready !== 1'b0 || dina !== 3'd1 || dinb !== 3'd2) begin errors++; $display("FAIL b2b_accept got ready %b dina %o dinb %o exp 0 1 2", start_ready, dina, dinb); end
      for (int k = 0; k < 4; k++) step();
      checks++; if (res_valid !== 1'b1 || result !== 12'o0033) begin errors++; $display("FAIL b2b_result got valid %b result %o exp 1 0033", res_valid, result); end
      consume();
   endtask

   task automatic test_reset_mid();
      int lat; logic [11:0] da, db; logic [3:0] ci;
      logic seen;
      a_in = 12'o3333; b_in = 12'o4444; cin_in = 1'b1; start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++; if (start_ready !== 1'b1 || res_valid !== 1'b0 || result !== 12'd0 || cout_out !== 1'b0) begin
         errors++; $display("FAIL midrst_state got ready %b valid %b result %o cout %b exp 1 0 0 0", start_ready, res_valid, result, cout_out);
      end
      checks++; if ({dina, dinb, cin} !== 7'd0) begin errors++; $display("FAIL midrst_adder_drive got %o %o %b exp 0", dina, dinb, cin); end
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (res_valid) seen = 1'b1;
         step();
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_pulse got 1 exp 0"); end
      issue(12'o0777, 12'o0001, 1'b1, lat, da, db, ci);
      checks++; if (lat !== 4 || result !== 12'o1001 || cout_out !== 1'b0) begin
         errors++; $display("FAIL midrst_recover got lat %0d result %o cout %b exp 4 1001 0", lat, result, cout_out);
      end
      consume();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_carry_in();
      test_ripple();
      test_digit_order();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
